rv32i_exec_core: RTL and testbench
==================================

Name: rv32i_exec_core

Overview:
- Combined RV32I decode/execute datapath for the multi-cycle processor: instruction field decoder, integer ALU and branch comparator in one block.
- Decode and compare are combinational. ALU result is registered, with one cycle of latency.
- The sequencer in top drives the instruction word and the operands. It samples the decoded fields, alu_result and branch_taken at its execute and writeback steps.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- instr  input  32  instruction word currently held for decode.
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7].
- funct3  output  3  instr[14:12].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- funct7  output  7  instr[31:25].
- imm  output  32  sign-extended immediate for the decoded format.
- alu_a  input  32  ALU operand A (rs1 value).
- alu_b  input  32  ALU operand B (rs2 value or imm).
- alu_result  output  32  registered ALU result.
- cmp_a  input  32  comparator operand 1.
- cmp_b  input  32  comparator operand 2.
- branch_taken  output  1  branch condition flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. Only alu_result is reset: if rst_n is low at a rising clk edge, alu_result becomes 0 on that edge.
- Decoder: purely combinational. Field outputs are direct bit slices and are valid for every opcode.
- imm by opcode:
  - 0010011, 0000011, 1100111 (I-type): sext(instr[31:20]).
  - 0100011 (S-type): sext({instr[31:25],instr[11:7]}).
  - 1100011 (B-type): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 0110111, 0010111 (U-type): {instr[31:12],12'b0}.
  - 1101111 (J-type): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - All other opcodes, including R-type: 0.
- ALU operation, selected by the decoded funct3 of the current instr:
  - 000: ADD. Becomes SUB only when opcode=0110011 and funct7[5]=1. I-type never subtracts, even if imm bit 10 is set.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1, for both R-type and I-type.
  - 110: OR.
  - 111: AND.
- ALU arithmetic rules:
  - Shift amount is alu_b[4:0].
  - SLT and SLTU return 32'd1 or 32'd0.
  - Overflow wraps modulo 2^32.
- ALU timing: the result is computed from alu_a, alu_b and the decoded fields present at edge N, and appears on alu_result after edge N. It holds until the next edge. The register updates on every edge; there is no enable.
- Comparator: combinational, selected by funct3.
  - 000: EQ.
  - 001: NE.
  - 100: signed LT.
  - 101: signed GE.
  - 110: unsigned LT.
  - 111: unsigned GE.
  - 010 and 011: flag 0.
  - branch_taken is valid for any opcode; the consumer qualifies it with opcode 1100011.
- Reset mid-operation: a pending ALU result is discarded and alu_result reads 0 for that cycle. Combinational outputs are unaffected by reset.
- Boundary cases:
  - SRA by 0 returns the operand unchanged.
  - SRA of 32'h80000000 by 31 gives 32'hFFFFFFFF.
  - SLT(32'h80000000, 0) gives 1; SLTU of the same operands gives 0.
  - A BEQ with both operands equal gives flag 1.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit, combinational). It is 1 when opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. It is also 1 for an R-type instruction with funct7 other than 0000000 or 0100000. It is 1 for a B-type instruction with funct3 of 010 or 011.
- Not defined: the port does not exist and there is no added logic. All other behaviour is identical.

Decomposition:
- Package rv32i_pkg holds:
  - Opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - ALU funct3 constants.
  - Branch funct3 constants.
- One sub-module, rv32i_imm_gen: the combinational immediate formatter (instr in, imm out). Decoder slicing, the ALU and the comparator stay in the top block.

Test Plan:
- instr=32'hFFF00093 (addi x1,x0,-1): opcode=0010011, rd=1, imm=32'hFFFFFFFF. With alu_a=5 and alu_b=imm, alu_result=4 one edge later.
- instr=32'h40208033 (sub x0,x1,x2), alu_a=3, alu_b=5: alu_result=32'hFFFFFFFE after one edge. Repeating with an I-type ADDI whose imm bit 10 is set gives the sum, not the difference.
- instr=32'h4010D093 (srai x1,x1,1), alu_a=32'h80000000, alu_b=imm: alu_result=32'hC0000000. With instr=32'h0010D093 (srli) the result is 32'h40000000.
- B-type instr=32'hFE0098E3 (bne x1,x0,-16): imm=32'hFFFFFFF0. cmp_a=cmp_b=7 gives branch_taken=0; cmp_a=7, cmp_b=8 gives 1. BLTU with cmp_a=32'hFFFFFFFF, cmp_b=1 gives 0; BLT with the same operands gives 1.
- J-type instr=32'h0080006F (jal x0,+8) gives imm=8. U-type instr=32'h123452B7 (lui) gives imm=32'h12345000 and rd=5. Store instr=32'hFE112E23 gives imm=32'hFFFFFFFC.
- Hold alu_a=1, alu_b=1 (ADD) and drive rst_n=0 for one edge: alu_result=0. Release rst_n: alu_result=2 on the next edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: major opcodes plus ALU and branch funct3 selectors.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate formatter: picks the encoding layout from the opcode
// and sign-extends it to 32 bits; formats without an immediate yield zero.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_core.sv
// RV32I decode/execute datapath: field decoder, registered ALU, branch comparator.
// Optional DECODE_ILLEGAL_EN adds a combinational 'illegal' instruction flag.
module rv32i_exec_core
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [31:0]     imm,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] cmp_a,
    input  logic [XLEN-1:0] cmp_b,
    output logic            branch_taken
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] sra_v;
    logic [4:0]      shamt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    rv32i_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    assign shamt = alu_b[4:0];
    // Kept apart so the arithmetic shift stays signed instead of being
    // demoted to logical inside the mixed-sign select below.
    assign sra_v = $signed(alu_a) >>> shamt;

    always_comb begin
        alu_d = '0;
        case (funct3)
            F3_ADD:  alu_d = (opcode == OP_R && funct7[5]) ? alu_a - alu_b : alu_a + alu_b;
            F3_SLL:  alu_d = alu_a << shamt;
            F3_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            F3_SLTU: alu_d = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            F3_XOR:  alu_d = alu_a ^ alu_b;
            F3_SR:   alu_d = funct7[5] ? sra_v : alu_a >> shamt;
            F3_OR:   alu_d = alu_a | alu_b;
            F3_AND:  alu_d = alu_a & alu_b;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    assign alu_result = alu_q;

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = (cmp_a == cmp_b);
            F3_BNE:  branch_taken = (cmp_a != cmp_b);
            F3_BLT:  branch_taken = ($signed(cmp_a) <  $signed(cmp_b));
            F3_BGE:  branch_taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: branch_taken = (cmp_a <  cmp_b);
            F3_BGEU: branch_taken = (cmp_a >= cmp_b);
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_R:      illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            OP_BRANCH: illegal = (funct3 == 3'b010 || funct3 == 3'b011);
            OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                       illegal = 1'b0;
            default:   illegal = 1'b1;
        endcase
    end
`endif

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Scoreboard bench for rv32i_exec_core: directed and random instructions checked
// against an arithmetic reference model.
module tb_rv32i_exec_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [31:0] alu_result;
    logic [31:0] cmp_a = '0;
    logic [31:0] cmp_b = '0;
    logic        branch_taken;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    rv32i_exec_core #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .imm          (imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .cmp_a        (cmp_a),
        .cmp_b        (cmp_b),
        .branch_taken (branch_taken)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegal      (illegal)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] imm;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int v;
        logic [6:0] op;
        op = ins[6:0];
        v = 0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67)
            v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        else if (op == 7'h23)
            v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
        else if (op == 7'h63)
            v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                - (ins[31] ? 4096 : 0);
        else if (op == 7'h37 || op == 7'h17)
            v = int'(ins[31:12]) * 4096;
        else if (op == 7'h6F)
            v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                - (ins[31] ? 1048576 : 0);
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        r = '0;
        case (ins[14:12])
            3'd0: r = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a;
                for (int unsigned k = 0; k < sh; k++)
                    r = {(ins[30] ? r[31] : 1'b0), r[31:1]};
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic m_br(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b);
        case (ins[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_ill(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17}))
            return 1'b1;
        if (op == 7'h33 && !(ins[31:25] inside {7'h00, 7'h20}))
            return 1'b1;
        if (op == 7'h63 && ins[14:12] inside {3'd2, 3'd3})
            return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("alu_result", alu_result, e.alu);
                chk("opcode", {25'b0, opcode}, {25'b0, e.instr[6:0]});
                chk("rd",     {27'b0, rd},     {27'b0, e.instr[11:7]});
                chk("funct3", {29'b0, funct3}, {29'b0, e.instr[14:12]});
                chk("rs1",    {27'b0, rs1},    {27'b0, e.instr[19:15]});
                chk("rs2",    {27'b0, rs2},    {27'b0, e.instr[24:20]});
                chk("funct7", {25'b0, funct7}, {25'b0, e.instr[31:25]});
                chk("imm", imm, e.imm);
                chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.br});
`ifdef DECODE_ILLEGAL_EN
                chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ca, input logic [31:0] cb, input logic rst);
        exp_t e;
        @(negedge clk);
        instr = ins;
        alu_a = a;
        alu_b = b;
        cmp_a = ca;
        cmp_b = cb;
        rst_n = rst;
        e.instr = ins;
        e.alu   = rst ? m_alu(ins, a, b) : 32'd0;
        e.imm   = m_imm(ins);
        e.br    = m_br(ins, ca, cb);
        e.ill   = m_ill(ins);
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : driver
        logic [6:0]  ops [9];
        logic [31:0] ins, a, b, ca, cb;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        issue(32'h0000_0033, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);   // reset state
        issue(32'hFFF0_0093, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
        issue(32'h4020_8033, 32'd3, 32'd5, 32'd0, 32'd0, 1'b1);
        issue(32'h4000_8093, 32'd3, 32'd5, 32'd0, 32'd0, 1'b1);   // addi imm bit 10 set
        issue(32'h4010_D093, 32'h8000_0000, 32'h0000_0401, 32'd0, 32'd0, 1'b1);
        issue(32'h0010_D093, 32'h8000_0000, 32'h0000_0001, 32'd0, 32'd0, 1'b1);
        issue(32'hFE00_98E3, 32'd0, 32'd0, 32'd7, 32'd7, 1'b1);
        issue(32'hFE00_98E3, 32'd0, 32'd0, 32'd7, 32'd8, 1'b1);
        issue(32'hFE00_E8E3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(32'hFE00_C8E3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(32'hFE00_88E3, 32'd0, 32'd0, 32'd5, 32'd5, 1'b1);
        issue(32'h0080_006F, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1);
        issue(32'h1234_52B7, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1);
        issue(32'hFE11_2E23, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1);
        issue(32'h4000_D033, 32'h8000_0001, 32'd0, 32'd0, 32'd0, 1'b1);   // sra by 0
        issue(32'h4000_D033, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b1);
        issue(32'h0000_2033, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b1);
        issue(32'h0000_3033, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b1);
        issue(32'h0000_0033, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);   // mid-run reset
        issue(32'h0000_0033, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) == 0)
                ins[6:0] = 7'($urandom);
            else
                ins[6:0] = ops[$urandom_range(0, 8)];
            if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            a = pick_operand();
            b = $urandom_range(0, 1) ? m_imm(ins) : pick_operand();
            ca = pick_operand();
            cb = $urandom_range(0, 2) == 0 ? ca : pick_operand();
            issue(ins, a, b, ca, cb, $urandom_range(0, 19) != 0);
        end

        @(posedge clk);
        #2;
        for (int k = 0; k < 10 && sbq.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sbq.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
